// File: rtl/lock_code_sender_if.sv
// Pattern-interface bundle between the controller side and the lock sender.
// Ports: start/abort/code and the lock LEDs feed the sender; pattern and status come back.
interface lock_code_sender_if;
  logic        start;
  logic        abort;
  logic [15:0] code;
  logic        green_led;
  logic        red_led;
  logic [3:0]  in_pattern;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic [3:0]  attempts;

  modport master (
    output start, abort, code, green_led, red_led,
    input  in_pattern, busy, done, pass, fail, attempts
  );

  modport slave (
    input  start, abort, code, green_led, red_led,
    output in_pattern, busy, done, pass, fail, attempts
  );
endinterface

// File: rtl/lock_code_sender.sv
// Plays a latched 4-nibble code into the FSM lock and retries on red/timeout.
// Ports: clk, rst (async high), bus (slave: start/abort/code/LEDs in, pattern/status out).
module lock_code_sender #(
  parameter logic [3:0] IDLE_PAT   = 4'b0000,
  parameter int         TIMEOUT    = 8,
  parameter int         GAP_CYCLES = 2,
  parameter int         MAX_TRIES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  lock_code_sender_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_GAP, S_FIN
  } state_t;

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] MAX_T    = 4'(MAX_TRIES);

  state_t      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  gap_q, gap_d;
  logic [3:0]  att_q, att_d;
  logic [3:0]  pat_q, pat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      step_q  <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      att_q   <= '0;
      pat_q   <= IDLE_PAT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      att_q   <= att_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Outputs are registered from the next state, so each
  // appears in the same cycle as the state it belongs to.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    step_d  = step_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    att_d   = att_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          code_d  = bus.code;
          att_d   = 4'd1;
          step_d  = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          state_d = S_FIN;
          fail_d  = 1'b1;
        end else begin
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = S_WAIT;
            timer_d = 8'd0;
          end
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          state_d = S_FIN;
          fail_d  = 1'b1;
        end else if (bus.green_led) begin
          state_d = S_FIN;
          pass_d  = 1'b1;
        end else if (bus.red_led || timer_q == TO_LAST) begin
          if (att_q < MAX_T) begin
            state_d = S_GAP;
            gap_d   = 4'd0;
          end else begin
            state_d = S_FIN;
            fail_d  = 1'b1;
          end
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_FIN;
          fail_d  = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          att_d   = att_q + 4'd1;
          step_d  = 2'd0;
          state_d = S_SEND;
        end else if (gap_q != 4'hF) begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_FIN);
    busy_d = (state_d == S_SEND) ||
             (state_d == S_WAIT) ||
             (state_d == S_GAP);
    pat_d  = (state_d == S_SEND) ?
             code_d[{step_d, 2'b00} +: 4] : IDLE_PAT;
  end

  assign bus.in_pattern = pat_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.attempts   = att_q;

endmodule
